// File: rtl/isqrt_dist_pkg.sv
// Shared types and sizing helpers for the isqrt sum distributor.
// Contents: FSM state enum, ceil_div helper, and the round count / round-counter
// width for the default configuration (3 arguments over 2 engines, 32-bit).
package isqrt_dist_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2
  } state_e;

  function automatic int unsigned ceil_div(input int unsigned a, input int unsigned b);
    return (a + b - 1) / b;
  endfunction

  localparam int unsigned N_ARGS_DEF  = 3;
  localparam int unsigned N_ISQRT_DEF = 2;
  localparam int unsigned W_DEF       = 32;
  localparam int unsigned R_DEF       = ceil_div(N_ARGS_DEF, N_ISQRT_DEF);
  localparam int unsigned RND_W_DEF   = $clog2(R_DEF + 1);

endpackage

// File: rtl/isqrt_dist_lane_mask.sv
// Combinational lane map for one round.
// Ports:
//   round  in   RND_W            current round number
//   active out  N_ISQRT          lane l carries an argument this round
//   idx    out  N_ISQRT*IDX_W    argument index carried by lane l (0 when idle)
module isqrt_dist_lane_mask
  import isqrt_dist_pkg::*;
#(
  parameter int unsigned N_ARGS  = N_ARGS_DEF,
  parameter int unsigned N_ISQRT = N_ISQRT_DEF,
  parameter int unsigned RND_W   = RND_W_DEF,
  parameter int unsigned IDX_W   = 2
) (
  input  logic [RND_W-1:0]         round,
  output logic [N_ISQRT-1:0]       active,
  output logic [N_ISQRT*IDX_W-1:0] idx
);

  int unsigned arg_i;

  // Lane l of round r maps to argument r*N_ISQRT+l when that index exists.
  always_comb begin
    active = '0;
    idx    = '0;
    arg_i  = 0;
    for (int unsigned l = 0; l < N_ISQRT; l++) begin
      arg_i = 32'(round) * N_ISQRT + l;
      if (arg_i < N_ARGS) begin
        active[l]                = 1'b1;
        idx[l*IDX_W +: IDX_W]    = IDX_W'(arg_i);
      end
    end
  end

endmodule

// File: rtl/isqrt_sum_fsm_distributor.sv
// Sums the integer square roots of N_ARGS arguments using N_ISQRT external
// isqrt engines, issuing the arguments in rounds of up to N_ISQRT lanes.
// Ports:
//   clk, rst (sync, active-high)
//   arg_vld/arg_rdy/args      job request; accepted in IDLE only
//   res_vld/res               one-cycle result pulse, res held until next accept
//   isqrt_x_vld/isqrt_x       per-lane operand issue
//   isqrt_y_vld/isqrt_y       per-lane root return, any latency, any skew
module isqrt_sum_fsm_distributor
  import isqrt_dist_pkg::*;
#(
  parameter int unsigned N_ARGS  = N_ARGS_DEF,
  parameter int unsigned N_ISQRT = N_ISQRT_DEF,
  parameter int unsigned W       = W_DEF
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     arg_vld,
  output logic                     arg_rdy,
  input  logic [N_ARGS*W-1:0]      args,
  output logic                     res_vld,
  output logic [W-1:0]             res,
  output logic [N_ISQRT-1:0]       isqrt_x_vld,
  output logic [N_ISQRT*W-1:0]     isqrt_x,
  input  logic [N_ISQRT-1:0]       isqrt_y_vld,
  input  logic [N_ISQRT*W/2-1:0]   isqrt_y
);

  localparam int unsigned R        = ceil_div(N_ARGS, N_ISQRT);
  localparam int unsigned RND_W    = $clog2(R + 1);
  localparam int unsigned IDX_W    = (N_ARGS > 1) ? $clog2(N_ARGS) : 1;
  localparam int unsigned RW       = W / 2;
  localparam logic [RND_W-1:0] LAST_RND = RND_W'(R - 1);

  state_e                   state_q, state_d;
  logic [RND_W-1:0]         round_q, round_d;
  logic [N_ISQRT-1:0]       active_q, active_d;
  logic [N_ISQRT-1:0]       done_q, done_d;
  logic [N_ISQRT-1:0]       x_vld_q, x_vld_d;
  logic [N_ISQRT*W-1:0]     x_q, x_d;
  logic [N_ARGS*W-1:0]      args_q, args_d;
  logic [W-1:0]             res_q, res_d;
  logic                     res_vld_q, res_vld_d;
  logic                     arg_rdy_q, arg_rdy_d;

  logic [N_ISQRT-1:0]       lane_mask_c;
  logic [N_ISQRT*IDX_W-1:0] lane_idx_c;
  logic [N_ISQRT-1:0]       new_c;
  logic [W-1:0]             add_c;
  int unsigned              src_i;

  // Lane map for the round the FSM is heading into.
  isqrt_dist_lane_mask #(
    .N_ARGS  (N_ARGS),
    .N_ISQRT (N_ISQRT),
    .RND_W   (RND_W),
    .IDX_W   (IDX_W)
  ) u_lane_mask (
    .round  (round_d),
    .active (lane_mask_c),
    .idx    (lane_idx_c)
  );

  // FSM next state and accumulator.
  always_comb begin
    state_d   = state_q;
    round_d   = round_q;
    args_d    = args_q;
    res_d     = res_q;
    done_d    = done_q;
    res_vld_d = 1'b0;
    new_c     = '0;
    add_c     = '0;
    case (state_q)
      IDLE: begin
        if (arg_vld) begin
          args_d  = args;
          res_d   = '0;
          round_d = '0;
          state_d = ISSUE;
        end
      end
      ISSUE: begin
        done_d  = '0;
        state_d = WAIT;
      end
      WAIT: begin
        // Only first strobe of an active lane counts; duplicates and idle lanes drop.
        new_c = isqrt_y_vld & active_q & ~done_q;
        for (int unsigned l = 0; l < N_ISQRT; l++) begin
          if (new_c[l]) add_c = add_c + W'(isqrt_y[l*RW +: RW]);
        end
        res_d  = res_q + add_c;
        done_d = done_q | new_c;
        if (&(done_d | ~active_q)) begin
          if (round_q == LAST_RND) begin
            state_d   = IDLE;
            res_vld_d = 1'b1;
          end else begin
            round_d = round_q + 1'b1;
            state_d = ISSUE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Registered outputs derived from the next state.
  always_comb begin
    active_d  = lane_mask_c;
    arg_rdy_d = (state_d == IDLE);
    x_vld_d   = (state_d == ISSUE) ? lane_mask_c : '0;
    x_d       = x_q;
    src_i     = 0;
    for (int unsigned l = 0; l < N_ISQRT; l++) begin
      src_i = 32'(lane_idx_c[l*IDX_W +: IDX_W]);
      if (lane_mask_c[l]) x_d[l*W +: W] = args_d[src_i*W +: W];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      round_q   <= '0;
      active_q  <= '0;
      done_q    <= '0;
      x_vld_q   <= '0;
      x_q       <= '0;
      args_q    <= '0;
      res_q     <= '0;
      res_vld_q <= 1'b0;
      arg_rdy_q <= 1'b1;
    end else begin
      state_q   <= state_d;
      round_q   <= round_d;
      active_q  <= active_d;
      done_q    <= done_d;
      x_vld_q   <= x_vld_d;
      x_q       <= x_d;
      args_q    <= args_d;
      res_q     <= res_d;
      res_vld_q <= res_vld_d;
      arg_rdy_q <= arg_rdy_d;
    end
  end

  assign arg_rdy     = arg_rdy_q;
  assign res_vld     = res_vld_q;
  assign res         = res_q;
  assign isqrt_x_vld = x_vld_q;
  assign isqrt_x     = x_q;

endmodule

// File: tb/tb_isqrt_sum_fsm_distributor.sv
// Bench for isqrt_sum_fsm_distributor: two instances (3 args and 5 args over
// 2 engines) driven by behavioural isqrt engines with per-lane latency.
module tb_isqrt_sum_fsm_distributor;
  import isqrt_dist_pkg::*;

  localparam int unsigned W    = 32;
  localparam int unsigned RW   = 16;
  localparam int unsigned NI   = 2;
  localparam int unsigned NA_A = 3;
  localparam int unsigned NA_B = 5;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic                a_arg_vld, a_arg_rdy, a_res_vld;
  logic [NA_A*W-1:0]   a_args;
  logic [W-1:0]        a_res;
  logic [NI-1:0]       a_x_vld, a_y_vld;
  logic [NI*W-1:0]     a_x;
  logic [NI*RW-1:0]    a_y;

  logic                b_arg_vld, b_arg_rdy, b_res_vld;
  logic [NA_B*W-1:0]   b_args;
  logic [W-1:0]        b_res;
  logic [NI-1:0]       b_x_vld, b_y_vld;
  logic [NI*W-1:0]     b_x;
  logic [NI*RW-1:0]    b_y;

  isqrt_sum_fsm_distributor #(.N_ARGS(NA_A), .N_ISQRT(NI), .W(W)) u_dut_a (
    .clk(clk), .rst(rst), .arg_vld(a_arg_vld), .arg_rdy(a_arg_rdy), .args(a_args),
    .res_vld(a_res_vld), .res(a_res), .isqrt_x_vld(a_x_vld), .isqrt_x(a_x),
    .isqrt_y_vld(a_y_vld), .isqrt_y(a_y)
  );

  isqrt_sum_fsm_distributor #(.N_ARGS(NA_B), .N_ISQRT(NI), .W(W)) u_dut_b (
    .clk(clk), .rst(rst), .arg_vld(b_arg_vld), .arg_rdy(b_arg_rdy), .args(b_args),
    .res_vld(b_res_vld), .res(b_res), .isqrt_x_vld(b_x_vld), .isqrt_x(b_x),
    .isqrt_y_vld(b_y_vld), .isqrt_y(b_y)
  );

  int n_vec = 0;
  int n_err = 0;

  task automatic check(input string tag, input longint unsigned got, input longint unsigned exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Reference integer square root, bit by bit from the top.
  function automatic int unsigned ref_isqrt(input logic [W-1:0] x);
    longint unsigned r, t;
    r = 0;
    for (int b = RW - 1; b >= 0; b--) begin
      t = r | (64'd1 << b);
      if (t * t <= 64'(x)) r = t;
    end
    return 32'(r);
  endfunction

  // Engine models: lanes 0,1 serve instance A, lanes 2,3 serve instance B.
  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int unsigned    lat[4];
  bit             dup_en;
  int unsigned    due_q[4][$];
  logic [RW-1:0]  val_q[4][$];
  logic [W-1:0]   iss_q[4][$];
  int             res_cnt[2] = '{0, 0};

  always @(negedge clk) begin
    logic [2*NI-1:0]    xv, yv;
    logic [2*NI*W-1:0]  xd;
    logic [2*NI*RW-1:0] yd;
    logic [W-1:0]       op;
    xv = {b_x_vld, a_x_vld};
    xd = {b_x, a_x};
    yv = '0;
    yd = '0;
    for (int l = 0; l < 4; l++) begin
      if (due_q[l].size() > 0 && due_q[l][0] == cyc) begin
        yv[l] = 1'b1;
        yd[l*RW +: RW] = val_q[l][0];
        void'(due_q[l].pop_front());
        void'(val_q[l].pop_front());
      end
      if (xv[l]) begin
        op = xd[l*W +: W];
        iss_q[l].push_back(op);
        due_q[l].push_back(cyc + lat[l]);
        val_q[l].push_back(RW'(ref_isqrt(op)));
        if (dup_en) begin
          due_q[l].push_back(cyc + lat[l] + 1);
          val_q[l].push_back(RW'(ref_isqrt(op)));
        end
      end
    end
    {b_y_vld, a_y_vld} = yv;
    {b_y, a_y}         = yd;
    if (a_res_vld) res_cnt[0]++;
    if (b_res_vld) res_cnt[1]++;
  end

  // Submit one job at a negedge; returns at the negedge where res_vld is seen.
  task automatic run_job(input int d, input logic [W-1:0] a[$], input string tag);
    int unsigned na, nr, exp_k, k, m, li;
    longint unsigned sum;
    bit got;
    na = (d == 0) ? NA_A : NA_B;
    nr = (na + NI - 1) / NI;
    sum = 0;
    foreach (a[i]) sum += ref_isqrt(a[i]);
    exp_k = 1;
    for (int unsigned r = 0; r < nr; r++) begin
      m = 0;
      for (int unsigned l = 0; l < NI; l++)
        if (r * NI + l < na && lat[d*NI+l] > m) m = lat[d*NI+l];
      exp_k += m + 1;
    end
    for (int l = 0; l < NI; l++) iss_q[d*NI+l].delete();
    check({tag, "/rdy"}, (d == 0) ? a_arg_rdy : b_arg_rdy, 1);
    if (d == 0) begin
      for (int i = 0; i < NA_A; i++) a_args[i*W +: W] = a[i];
      a_arg_vld = 1'b1;
    end else begin
      for (int i = 0; i < NA_B; i++) b_args[i*W +: W] = a[i];
      b_arg_vld = 1'b1;
    end
    @(posedge clk);
    @(negedge clk);
    a_arg_vld = 1'b0;
    b_arg_vld = 1'b0;
    k = 1;
    got = 0;
    while (!got && k < 300) begin
      if ((d == 0) ? a_res_vld : b_res_vld) got = 1;
      else begin
        @(negedge clk);
        k++;
      end
    end
    check({tag, "/seen"}, got, 1);
    check({tag, "/lat"}, k, exp_k);
    check({tag, "/res"}, (d == 0) ? a_res : b_res, 32'(sum));
    for (int unsigned l = 0; l < NI; l++) begin
      li = d * NI + l;
      check({tag, "/issue_cnt"}, iss_q[li].size(), (na > l) ? (na - l + NI - 1) / NI : 0);
      for (int unsigned j = l, n = 0; j < na; j += NI, n++)
        if (n < iss_q[li].size()) check({tag, "/issue_op"}, iss_q[li][n], a[j]);
    end
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

  initial begin
    logic [W-1:0] v[$];
    int c0, d, na;
    logic [W-1:0] x;

    rst = 1'b1;
    a_arg_vld = 1'b0; b_arg_vld = 1'b0;
    a_args = '0; b_args = '0;
    lat = '{4, 4, 4, 4};
    dup_en = 0;
    repeat (3) @(negedge clk);
    check("rst/rdy", a_arg_rdy, 1);
    check("rst/res_vld", a_res_vld, 0);
    check("rst/res", a_res, 0);
    check("rst/x_vld", {b_x_vld, a_x_vld}, 0);
    rst = 1'b0;
    @(negedge clk);

    v = '{32'd16, 32'd25, 32'd9};
    run_job(0, v, "t1");
    repeat (2) @(negedge clk);

    v = '{32'd1, 32'd4, 32'd9, 32'd16, 32'd25};
    run_job(1, v, "t2");
    repeat (2) @(negedge clk);

    lat[0] = 2; lat[1] = 7;
    v = '{32'd100, 32'd49, 32'd0};
    run_job(0, v, "t3");
    repeat (10) @(negedge clk);

    lat[0] = 4; lat[1] = 4;
    v = '{32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF};
    run_job(0, v, "t4a");
    run_job(0, v, "t4b");
    repeat (3) @(negedge clk);
    check("t4/hold_res", a_res, 196605);
    check("t4/hold_vld", a_res_vld, 0);

    // Abort during WAIT of round 0; the pending roots return into IDLE.
    c0 = res_cnt[0];
    for (int i = 0; i < NA_A; i++) a_args[i*W +: W] = 32'd9;
    a_arg_vld = 1'b1;
    @(posedge clk);
    @(negedge clk);
    a_arg_vld = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("t5/rdy", a_arg_rdy, 1);
    check("t5/x_vld", a_x_vld, 0);
    repeat (12) @(negedge clk);
    check("t5/no_res_vld", res_cnt[0] - c0, 0);
    v = '{32'd4, 32'd4, 32'd4};
    run_job(0, v, "t5");
    repeat (2) @(negedge clk);

    // arg_vld held while busy with changing args.
    c0 = res_cnt[0];
    for (int i = 0; i < NA_A; i++) a_args[i*W +: W] = 32'd36 + 32'(i) * 32'd45;
    a_arg_vld = 1'b1;
    @(posedge clk);
    repeat (6) begin
      @(negedge clk);
      a_args = {$urandom, $urandom, $urandom};
    end
    @(negedge clk);
    a_arg_vld = 1'b0;
    repeat (30) @(negedge clk);
    check("t6/res_vld_cnt", res_cnt[0] - c0, 1);
    check("t6/res", a_res, 6 + 9 + 11);

    // Randomized jobs, random latency, duplicate strobes and back-to-back submits.
    for (int j = 0; j < 30; j++) begin
      d = $urandom_range(0, 1);
      na = (d == 0) ? NA_A : NA_B;
      for (int l = 0; l < NI; l++) lat[d*NI+l] = $urandom_range(1, 6);
      dup_en = 1'($urandom_range(0, 1));
      v.delete();
      for (int i = 0; i < na; i++) begin
        case ($urandom_range(0, 2))
          0: x = $urandom;
          1: x = 32'($urandom_range(0, 1000));
          default: x = 32'hFFFF_FFFF;
        endcase
        v.push_back(x);
      end
      run_job(d, v, "rand");
      if ($urandom_range(0, 2) != 0) repeat ($urandom_range(1, 3)) @(negedge clk);
    end
    repeat (10) @(negedge clk);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
